// File: rtl/minx16_mul_seq.sv
// minx16_mul_seq: 16x16 unsigned shift-add multiplier stepping the shared Minx16 ALU.
// Define MINX16_MUL_EARLY_EN to skip the PASS cycle for zero multiplier bits.
module minx16_mul_seq #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] opa,
    input  logic [WIDTH-1:0] opb,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] prod_hi,
    output logic [WIDTH-1:0] prod_lo,
    output logic [3:0]       alu_op,
    output logic [WIDTH-1:0] alu_dba,
    output logic [WIDTH-1:0] alu_dbb,
    output logic             alu_ci,
    output logic             alu_op8,
    input  logic [WIDTH-1:0] alu_y,
    input  logic             alu_co
);
    localparam logic [3:0] OP_NOP  = 4'b0000;
    localparam logic [3:0] OP_PASS = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0100;
    localparam logic [3:0] OP_RRC  = 4'b1111;

    typedef enum logic [2:0] {S_IDLE, S_ADD, S_SHH, S_SHL, S_DONE} state_t;

    state_t           r_state, w_next;
    logic [WIDTH-1:0] r_acc, r_mq, r_mcand;
    logic             r_c;
    logic [CNT_W-1:0] r_cnt;
    logic             w_last, w_skip_idle, w_skip_shl;

    assign w_last = r_cnt == CNT_W'(WIDTH - 1);
`ifdef MINX16_MUL_EARLY_EN
    assign w_skip_idle = !opb[0];
    assign w_skip_shl  = !alu_y[0];
`else
    assign w_skip_idle = 1'b0;
    assign w_skip_shl  = 1'b0;
`endif

    assign busy    = r_state != S_IDLE;
    assign done    = r_state == S_DONE;
    assign alu_op8 = 1'b0;

    always_comb begin
        w_next  = r_state;
        alu_op  = OP_NOP;
        alu_dba = '0;
        alu_dbb = '0;
        alu_ci  = 1'b0;
        case (r_state)
            S_IDLE: w_next = start ? (w_skip_idle ? S_SHH : S_ADD) : S_IDLE;
            S_ADD: begin
                alu_op  = r_mq[0] ? OP_ADD : OP_PASS;
                alu_dba = r_acc;
                alu_dbb = r_mq[0] ? r_mcand : '0;
                w_next  = S_SHH;
            end
            S_SHH: begin
                alu_op  = OP_RRC;
                alu_dba = r_acc;
                alu_ci  = r_c;
                w_next  = S_SHL;
            end
            S_SHL: begin
                alu_op  = OP_RRC;
                alu_dba = r_mq;
                alu_ci  = r_c;
                w_next  = w_last ? S_DONE : (w_skip_shl ? S_SHH : S_ADD);
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_acc   <= '0;
            r_mq    <= '0;
            r_mcand <= '0;
            r_c     <= 1'b0;
            r_cnt   <= '0;
            prod_hi <= '0;
            prod_lo <= '0;
        end else begin
            r_state <= w_next;
            case (r_state)
                S_IDLE: if (start) begin
                    r_mcand <= opa;
                    r_mq    <= opb;
                    r_acc   <= '0;
                    r_c     <= 1'b0;
                    r_cnt   <= '0;
                end
                S_ADD, S_SHH: begin
                    r_acc <= alu_y;
                    r_c   <= alu_co;
                end
                S_SHL: begin
                    // carry is spent here; clearing it lets a skipped ADD enter SHH cleanly
                    r_mq  <= alu_y;
                    r_c   <= 1'b0;
                    r_cnt <= r_cnt + CNT_W'(1);
                    if (w_last) begin
                        prod_hi <= r_acc;
                        prod_lo <= alu_y;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule
